// File: rtl/piso_shift_register.sv
// -----------------------------------------------------------------------------
// piso_shift_register
//   Parallel-in serial-out shift stage. Accepts a WIDTH-bit word under a
//   valid/ready handshake and emits it one bit per clock on o_sout, flagged by
//   o_sout_valid. o_done marks the last bit of each word. A new word can be
//   accepted on the done cycle, so consecutive words stream with no idle gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   i_in          in   WIDTH  parallel word from the upstream register
//   i_in_valid    in   1      i_in carries a word to load
//   o_in_ready    out  1      a word can be accepted this cycle
//   o_sout        out  1      serial data bit
//   o_sout_valid  out  1      o_sout carries a valid bit this cycle
//   o_done        out  1      o_sout is the last bit of the word
// -----------------------------------------------------------------------------
module piso_shift_register #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_in,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_sout,
   output logic             o_sout_valid,
   output logic             o_done
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_cnt;   // bits already sent in the current word

   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_shifted;

   // Last bit of the word is on the output this cycle.
   assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

   // Ready is also gated by rst_n so nothing is accepted while reset is held.
   assign o_in_ready = rst_n & ((r_state == IDLE) | w_last);
   assign w_accept   = i_in_valid & o_in_ready;

   // Move the next bit toward the output end, zero-filling behind it.
   assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shreg <= i_in;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_cnt != LAST) begin
                  r_shreg <= w_shifted;
                  r_cnt   <= r_cnt + 1'b1;
               end else if (w_accept) begin
                  // Reload on the done edge: next word starts with no gap.
                  r_shreg <= i_in;
                  r_cnt   <= '0;
               end else begin
                  r_shreg <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_shreg <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; nothing from i_in/i_in_valid.
   assign o_sout_valid = (r_state == SHIFT);
   assign o_sout       = o_sout_valid &
                         (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
   assign o_done       = w_last;

endmodule

// File: tb/tb_piso_shift_register.sv
// Testbench for piso_shift_register: one MSB-first and one LSB-first instance
// share the same stimulus; a queue of (word, bit index) entries predicts the
// serial stream for both.
module tb_piso_shift_register;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] din = '0;
   logic         vin = 1'b0;

   logic rdy_m, so_m, sv_m, dn_m;
   logic rdy_l, so_l, sv_l, dn_l;

   piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .i_in(din), .i_in_valid(vin),
      .o_in_ready(rdy_m), .o_sout(so_m), .o_sout_valid(sv_m), .o_done(dn_m));

   piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .i_in(din), .i_in_valid(vin),
      .o_in_ready(rdy_l), .o_sout(so_l), .o_sout_valid(sv_l), .o_done(dn_l));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each queued entry is one bit still to appear on sout; the head is the
   // bit on the wire this cycle.
   typedef struct {
      logic [W-1:0] w;
      int           idx;
   } ent_t;
   ent_t q[$];
   int   acc_cnt = 0;

   function automatic bit m_ready();
      return rst_n && (q.size() <= 1);
   endfunction

   always @(negedge rst_n) q.delete();

   always @(posedge clk) begin
      logic acc;
      if (rst_n) begin
         acc = vin && m_ready();
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            for (int i = 0; i < W; i++) q.push_back('{din, i});
            acc_cnt++;
         end
      end
   end

   // ---------------- per-cycle compare + stream log ----------------
   logic [63:0] log_m = '0, log_l = '0, log_d = '0;
   int          nvalid = 0;

   always @(negedge clk) begin
      logic ev, ed, em, el;
      ev = 1'b0; ed = 1'b0; em = 1'b0; el = 1'b0;
      if (q.size() > 0) begin
         ev = 1'b1;
         ed = (q[0].idx == W - 1);
         em = q[0].w[W-1-q[0].idx];
         el = q[0].w[q[0].idx];
      end
      chk("ready_msb", rdy_m, m_ready());
      chk("ready_lsb", rdy_l, m_ready());
      chk("valid_msb", sv_m, ev);
      chk("valid_lsb", sv_l, ev);
      chk("done_msb", dn_m, ed);
      chk("done_lsb", dn_l, ed);
      chk("sout_msb", so_m, em);
      chk("sout_lsb", so_l, el);
      if (sv_m === 1'b1) begin
         log_m = {log_m[62:0], so_m};
         log_d = {log_d[62:0], dn_m};
         nvalid++;
      end
      if (sv_l === 1'b1) log_l = {log_l[62:0], so_l};
   end

   // ---------------- stimulus helpers ----------------
   // Present a word and hold it until the model sees it accepted; returns
   // just after the accepting edge with i_in_valid still high.
   task automatic send(input logic [W-1:0] w);
      int a0;
      a0  = acc_cnt;
      din = w;
      vin = 1'b1;
      for (int i = 0; i < 40 && acc_cnt == a0; i++) begin
         @(posedge clk);
         #1;
      end
      if (acc_cnt == a0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) chk("idle_timeout", 0, 1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n0, n1, a0, edges;

      // 1: async reset, no clock edge needed
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_valid_m", sv_m, 0);
      chk("t1_rst_valid_l", sv_l, 0);
      chk("t1_rst_sout_m", so_m, 0);
      chk("t1_rst_done_m", dn_m, 0);
      chk("t1_rst_ready_m", rdy_m, 0);
      chk("t1_rst_ready_l", rdy_l, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("t1_ready_after_rst", rdy_m, 1);
      chk("t1_ready_after_rst_l", rdy_l, 1);

      // 2: single word 12, MSB first -> 00001100
      @(negedge clk); #1;
      n0 = nvalid;
      send(8'd12);
      vin = 1'b0;
      wait_idle();
      chk("t2_bits", log_m[7:0], 8'd12);
      chk("t2_done_pos", log_d[7:0], 8'h01);
      chk("t2_count", nvalid - n0, 8);
      chk("t2_idle_valid", sv_m, 0);

      // 3: back-to-back 39 then 72
      n0 = nvalid;
      send(8'd39);
      send(8'd72);
      vin = 1'b0;
      wait_idle();
      chk("t3_bits", log_m[15:0], 16'h2748);
      chk("t3_done_pos", log_d[15:0], 16'h0101);
      chk("t3_count", nvalid - n0, 16);

      // 4: word 110 on the LSB-first instance -> 0,1,1,1,0,1,1,0
      send(8'd110);
      vin = 1'b0;
      wait_idle();
      chk("t4_lsb_bits", log_l[7:0], 8'b01110110);
      chk("t4_msb_bits", log_m[7:0], 8'd110);

      // 5: change to 57 mid-word; only taken on the done cycle
      n0 = nvalid;
      send(8'd200);
      vin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a0 = acc_cnt;
      din = 8'd57;
      vin = 1'b1;
      edges = 0;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
         @(posedge clk);
         #1;
         edges++;
      end
      vin = 1'b0;
      chk("t5_accept_edge", edges, 5);
      wait_idle();
      chk("t5_bits", log_m[15:0], {8'd200, 8'd57});
      chk("t5_count", nvalid - n0, 16);

      // 6: reset pulse after the 4th bit of 110
      n0 = nvalid;
      send(8'd110);
      vin = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid_m", sv_m, 0);
      chk("t6_rst_valid_l", sv_l, 0);
      chk("t6_rst_done_l", dn_l, 0);
      chk("t6_bits_before", nvalid - n0, 4);
      chk("t6_lsb_prefix", log_l[3:0], 4'b0111);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("t6_ready_after", rdy_l, 1);
      n1 = nvalid;
      repeat (12) @(negedge clk);
      #1;
      chk("t6_no_residual", nvalid - n1, 0);

      // Random traffic with occasional reset pulses
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         #1;
         vin = ($urandom_range(0, 99) < 60);
         din = W'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      vin = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
